// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter in front of a single-port
// synchronous RAM. Port 0 is the data port, port 1 the fetch port.
// Each transaction takes three cycles: IDLE (arbitrate and latch),
// ACCESS (drive the RAM), DONE (acknowledge and return read data).
// Optional feature macro: RAM_ARB_FETCH_READONLY_EN turns port 1 into a
// read-only port. Port-1 writes then complete without touching the RAM and
// raise ERR1 together with ACK1.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic                  WE0,
  input  logic                  WE1,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic [DATA_WIDTH-1:0] WDATA0,
  input  logic [DATA_WIDTH-1:0] WDATA1,
  output logic                  GNT0,
  output logic                  GNT1,
  output logic                  ACK0,
  output logic                  ACK1,
  output logic                  ERR1,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [ADDR_WIDTH-1:0] RAM_ADDRESS,
  output logic [DATA_WIDTH-1:0] RAM_DATA_IN,
  output logic                  RAM_WRITE_ENABLE,
  input  logic [DATA_WIDTH-1:0] RAM_DATA_OUT
);

`ifdef RAM_ARB_FETCH_READONLY_EN
  localparam bit FetchReadOnly = 1'b1;
`else
  localparam bit FetchReadOnly = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    winner_q, winner_d;   // 0 = port 0, 1 = port 1
  logic                    last_q, last_d;       // port granted most recently
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    pick;
  logic                    blocked_write;

  // State and latched-transaction registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      winner_q <= 1'b0;
      last_q   <= 1'b1;  // "port 1 last" gives port 0 the first tie
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, then step ACCESS -> DONE -> IDLE.
  // NOTE: every variable gets a default first so no path leaves a latch.
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    pick     = 1'b0;
    case (state_q)
      IDLE: begin
        if (REQ0 || REQ1) begin
          // On a tie the port that was not granted last wins.
          pick     = (REQ0 && REQ1) ? ~last_q : REQ1;
          winner_d = pick;
          last_d   = pick;
          we_d     = pick ? WE1 : WE0;
          addr_d   = pick ? ADDR1 : ADDR0;
          wdata_d  = pick ? WDATA1 : WDATA0;
          state_d  = ACCESS;
        end
      end
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A port-1 write that the read-only option suppresses.
  assign blocked_write = FetchReadOnly && winner_q && we_q;

  // Output decode: strobes only in their own state, all else low.
  always_comb begin
    GNT0             = 1'b0;
    GNT1             = 1'b0;
    ACK0             = 1'b0;
    ACK1             = 1'b0;
    ERR1             = 1'b0;
    RAM_WRITE_ENABLE = 1'b0;
    RDATA            = '0;
    case (state_q)
      ACCESS: begin
        GNT0             = ~winner_q;
        GNT1             = winner_q;
        RAM_WRITE_ENABLE = we_q && !blocked_write;
      end
      DONE: begin
        ACK0  = ~winner_q;
        ACK1  = winner_q;
        ERR1  = blocked_write;
        RDATA = RAM_DATA_OUT;
      end
      default: ;
    endcase
  end

  // Address and write data hold the latched values until the next grant.
  assign RAM_ADDRESS = addr_q;
  assign RAM_DATA_IN = wdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized and directed bench for ram_arbiter.
// A behavioural RAM sits on the RAM side. A transaction-level reference
// model (shadow memory + round-robin rule) predicts grants, acks and data.
module tb_ram_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
`ifdef RAM_ARB_FETCH_READONLY_EN
  localparam bit READONLY = 1'b1;
`else
  localparam bit READONLY = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          REQ0 = 1'b0, REQ1 = 1'b0, WE0 = 1'b0, WE1 = 1'b0;
  logic [AW-1:0] ADDR0 = '0, ADDR1 = '0;
  logic [DW-1:0] WDATA0 = '0, WDATA1 = '0;
  logic          GNT0, GNT1, ACK0, ACK1, ERR1, RAM_WRITE_ENABLE;
  logic [DW-1:0] RDATA, RAM_DATA_IN;
  logic [DW-1:0] RAM_DATA_OUT = '0;
  logic [AW-1:0] RAM_ADDRESS;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1), .ACK0(ACK0), .ACK1(ACK1), .ERR1(ERR1),
    .RDATA(RDATA), .RAM_ADDRESS(RAM_ADDRESS), .RAM_DATA_IN(RAM_DATA_IN),
    .RAM_WRITE_ENABLE(RAM_WRITE_ENABLE), .RAM_DATA_OUT(RAM_DATA_OUT)
  );

  always #5 CLK = ~CLK;

  // Behavioural synchronous RAM, read-before-write.
  logic [DW-1:0] ram [2**AW];
  always @(posedge CLK) begin
    if (RAM_WRITE_ENABLE) ram[RAM_ADDRESS] <= RAM_DATA_IN;
    RAM_DATA_OUT <= ram[RAM_ADDRESS];
  end

  // Reference model state.
  typedef struct {
    bit            valid;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;

  op_t           pend [2];
  logic [DW-1:0] shadow [2**AW];
  int            last_granted;
  int            grant_log [$];
  logic [DW-1:0] last_rdata;
  int            total = 0;
  int            bad   = 0;

  // Protocol monitor: the two grants, the two acks never overlap and the
  // RAM is never written outside a grant.
  always @(negedge CLK) begin
    if (!RESET && (GNT0 || GNT1 || ACK0 || ACK1 || RAM_WRITE_ENABLE)) begin
      total++;
      if ((GNT0 && GNT1) || (ACK0 && ACK1) || (RAM_WRITE_ENABLE && !(GNT0 || GNT1))) begin
        bad++;
        $display("FAIL monitor: gnt=%b%b ack=%b%b we=%b", GNT0, GNT1, ACK0, ACK1, RAM_WRITE_ENABLE);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_reqs();
    REQ0 = pend[0].valid; WE0 = pend[0].we; ADDR0 = pend[0].addr; WDATA0 = pend[0].wdata;
    REQ1 = pend[1].valid; WE1 = pend[1].we; ADDR1 = pend[1].addr; WDATA1 = pend[1].wdata;
  endtask

  task automatic set_op(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend[p].valid = 1'b1; pend[p].we = we; pend[p].addr = a; pend[p].wdata = d;
  endtask

  task automatic apply_reset();
    RESET = 1'b1;
    pend[0].valid = 1'b0;
    pend[1].valid = 1'b0;
    drive_reqs();
    tick();
    tick();
    RESET = 1'b0;
    last_granted = 1;  // port 0 wins the first tie after reset
  endtask

  // One arbitration round from IDLE: either an idle cycle or a full
  // three-cycle transaction of the predicted winner.
  task automatic serve_round();
    int            w;
    bit            exp_we, exp_err;
    logic [5:0]    exp_v, got_v;
    logic [AW-1:0] held;
    held = RAM_ADDRESS;
    drive_reqs();
    if (!pend[0].valid && !pend[1].valid) begin
      tick();
      total++;
      got_v = {GNT0, GNT1, ACK0, ACK1, ERR1, RAM_WRITE_ENABLE};
      if (got_v !== 6'b0 || RAM_ADDRESS !== held) begin
        bad++;
        $display("FAIL idle: strobes=%b addr=%0d, want 000000 addr=%0d", got_v, RAM_ADDRESS, held);
      end
      return;
    end
    if (pend[0].valid && pend[1].valid) w = 1 - last_granted;
    else w = pend[1].valid ? 1 : 0;
    exp_we  = pend[w].we && !(READONLY && w == 1);
    exp_err = READONLY && w == 1 && pend[w].we;

    tick();  // ACCESS
    got_v = {GNT0, GNT1, ACK0, ACK1, ERR1, RAM_WRITE_ENABLE};
    exp_v = {w == 0, w == 1, 1'b0, 1'b0, 1'b0, exp_we};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL access strobes: got %b want %b (port %0d)", got_v, exp_v, w);
    end
    total++;
    if (RAM_ADDRESS !== pend[w].addr || RAM_DATA_IN !== pend[w].wdata) begin
      bad++;
      $display("FAIL access bus: addr=%0d data=%0d want addr=%0d data=%0d",
               RAM_ADDRESS, RAM_DATA_IN, pend[w].addr, pend[w].wdata);
    end

    tick();  // DONE
    got_v = {GNT0, GNT1, ACK0, ACK1, ERR1, RAM_WRITE_ENABLE};
    exp_v = {1'b0, 1'b0, w == 0, w == 1, exp_err, 1'b0};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL done strobes: got %b want %b (port %0d)", got_v, exp_v, w);
    end
    last_rdata = RDATA;
    if (!pend[w].we) begin
      total++;
      if (RDATA !== shadow[pend[w].addr]) begin
        bad++;
        $display("FAIL rdata: addr=%0d got %0d want %0d", pend[w].addr, RDATA, shadow[pend[w].addr]);
      end
    end
    if (exp_we) shadow[pend[w].addr] = pend[w].wdata;
    last_granted = w;
    grant_log.push_back(w);
    pend[w].valid = 1'b0;

    tick();  // back in IDLE
    got_v = {GNT0, GNT1, ACK0, ACK1, ERR1, RAM_WRITE_ENABLE};
    total++;
    if (got_v !== 6'b0 || RAM_ADDRESS !== pend[w].addr) begin
      bad++;
      $display("FAIL post-done: strobes=%b addr=%0d want 000000 addr=%0d", got_v, RAM_ADDRESS, pend[w].addr);
    end
    drive_reqs();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #2;
    total++;
    if ({GNT0, GNT1, ACK0, ACK1, ERR1, RAM_WRITE_ENABLE} !== 6'b0 ||
        RAM_ADDRESS !== '0 || RAM_DATA_IN !== '0) begin
      bad++;
      $display("FAIL reset: gnt=%b%b ack=%b%b err=%b we=%b addr=%0d din=%0d",
               GNT0, GNT1, ACK0, ACK1, ERR1, RAM_WRITE_ENABLE, RAM_ADDRESS, RAM_DATA_IN);
    end
    apply_reset();
    serve_round();  // no request: must stay idle
  endtask

  task automatic test_port0_basic();
    set_op(0, 1'b1, 10'd1, 32'd24);
    serve_round();
    set_op(0, 1'b0, 10'd1, 32'd0);
    serve_round();
    total++;
    if (last_rdata !== 32'd24) begin
      bad++;
      $display("FAIL port0 readback: got %0d want 24", last_rdata);
    end
  endtask

  task automatic test_port1_and_max();
    logic [DW-1:0] want;
    set_op(1, 1'b1, 10'd2, 32'd61);
    serve_round();
    set_op(1, 1'b0, 10'd2, 32'd0);
    serve_round();
    want = READONLY ? 32'd0 : 32'd61;
    total++;
    if (last_rdata !== want) begin
      bad++;
      $display("FAIL port1 readback: got %0d want %0d", last_rdata, want);
    end
    set_op(0, 1'b1, 10'd1023, 32'd5);
    serve_round();
    set_op(0, 1'b0, 10'd1023, 32'd0);
    serve_round();
    total++;
    if (last_rdata !== 32'd5) begin
      bad++;
      $display("FAIL top-address readback: got %0d want 5", last_rdata);
    end
  endtask

  task automatic test_round_robin();
    int want [4];
    want = '{0, 1, 0, 1};
    apply_reset();
    grant_log.delete();
    set_op(0, 1'b1, 10'd20, 32'd100);
    set_op(1, 1'b0, 10'd20, 32'd0);
    for (int i = 0; i < 4; i++) begin
      serve_round();
      // The winner issues its next transaction at once, so both REQs stay high.
      if (!pend[0].valid) set_op(0, 1'b1, 10'(21 + i), 32'(200 + i));
      if (!pend[1].valid) set_op(1, 1'b0, 10'(20 + i), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (grant_log.size() <= i || grant_log[i] !== want[i]) begin
        bad++;
        $display("FAIL round-robin order[%0d]: got %0d want %0d", i,
                 (grant_log.size() > i) ? grant_log[i] : -1, want[i]);
      end
    end
    serve_round();
    serve_round();
  endtask

  task automatic test_readonly();
    logic [DW-1:0] want;
    set_op(1, 1'b1, 10'd2, 32'd99);
    serve_round();
    set_op(1, 1'b0, 10'd2, 32'd0);
    serve_round();
    want = READONLY ? 32'd0 : 32'd99;
    total++;
    if (last_rdata !== want) begin
      bad++;
      $display("FAIL readonly readback: got %0d want %0d", last_rdata, want);
    end
  endtask

  task automatic test_reset_mid_access();
    int acks;
    set_op(0, 1'b1, 10'd3, 32'd7);
    drive_reqs();
    tick();  // ACCESS of the write
    total++;
    if (GNT0 !== 1'b1) begin
      bad++;
      $display("FAIL cut write grant: got %b want 1", GNT0);
    end
    #3 RESET = 1'b1;
    #1;
    total++;
    if ({GNT0, GNT1, ACK0, ACK1, ERR1, RAM_WRITE_ENABLE} !== 6'b0 ||
        RAM_ADDRESS !== '0 || RAM_DATA_IN !== '0) begin
      bad++;
      $display("FAIL mid-access reset: strobes=%b addr=%0d din=%0d",
               {GNT0, GNT1, ACK0, ACK1, ERR1, RAM_WRITE_ENABLE}, RAM_ADDRESS, RAM_DATA_IN);
    end
    pend[0].valid = 1'b0;
    drive_reqs();
    tick();
    tick();
    #2 RESET = 1'b0;
    last_granted = 1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ACK0 || ACK1) acks++;
    end
    total++;
    if (acks !== 0) begin
      bad++;
      $display("FAIL cut transaction acked: got %0d acks want 0", acks);
    end
    set_op(0, 1'b0, 10'd3, 32'd0);
    serve_round();
    total++;
    if (last_rdata !== 32'd0) begin
      bad++;
      $display("FAIL cut write reached RAM: addr 3 got %0d want 0", last_rdata);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int i = 0; i < 80; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p].valid && $urandom_range(0, 99) < 65) begin
          case ($urandom_range(0, 3))
            0:       a = '0;
            1:       a = '1;
            2:       a = AW'($urandom_range(0, 7));
            default: a = AW'($urandom);
          endcase
          set_op(p, 1'($urandom), a, $urandom);
        end
      end
      serve_round();
    end
    pend[0].valid = 1'b0;
    pend[1].valid = 1'b0;
    serve_round();
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      ram[i]    = '0;
      shadow[i] = '0;
    end
    pend[0] = '{1'b0, 1'b0, '0, '0};
    pend[1] = '{1'b0, 1'b0, '0, '0};
    last_granted = 1;
    last_rdata   = '0;
    test_reset();
    test_port0_basic();
    test_port1_and_max();
    test_round_robin();
    test_readonly();
    test_reset_mid_access();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
